// File: rtl/ec_serial_harness.sv
// Serial start/done transaction harness for EC arithmetic cores: receives a framed operand,
// launches the core, returns a framed result with status. Optional watchdog: EC_HARNESS_TIMEOUT_EN.
module ec_serial_harness #(
  parameter int IN_WIDTH       = 286,
  parameter int OUT_WIDTH      = 567,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 test_i,
  output logic                 test_o,
  output logic [IN_WIDTH-1:0]  core_word_o,
  output logic                 core_start,
  output logic                 core_clr,
  input  logic                 core_done,
  input  logic [OUT_WIDTH-1:0] core_word_i,
  output logic                 busy
);

  localparam int MAXW = (IN_WIDTH > OUT_WIDTH + 2) ? IN_WIDTH : OUT_WIDTH + 2;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] RX_LAST  = CW'(IN_WIDTH - 1);
  localparam logic [CW-1:0] TX_LAST  = CW'(OUT_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RX     = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_TX     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // The final received bit goes straight to core_word_o, so only IN_WIDTH-1 bits are held.
  logic [IN_WIDTH-2:0]  rx_q, rx_d;
  logic [IN_WIDTH-1:0]  word_q, word_d;
  logic [OUT_WIDTH:0]   tx_q, tx_d;
  logic                 test_o_q, test_o_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 timeout_s;

`ifdef EC_HARNESS_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_ZERO = {WDW{1'b0}};
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           clr_q, clr_d;

  assign timeout_s = (wd_q == WD_LAST);
  assign core_clr  = clr_q;
`else
  assign timeout_s = 1'b0;
  assign core_clr  = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      rx_q     <= {(IN_WIDTH-1){1'b0}};
      word_q   <= {IN_WIDTH{1'b0}};
      tx_q     <= {(OUT_WIDTH+1){1'b0}};
      test_o_q <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef EC_HARNESS_TIMEOUT_EN
      wd_q     <= WD_ZERO;
      clr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      word_q   <= word_d;
      tx_q     <= tx_d;
      test_o_q <= test_o_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
`ifdef EC_HARNESS_TIMEOUT_EN
      wd_q     <= wd_d;
      clr_q    <= clr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = test_i ? S_RX : S_IDLE;
      S_RX:     state_d = (cnt_q == RX_LAST) ? S_LAUNCH : S_RX;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done || timeout_s) state_d = S_TX;
        else                        state_d = S_WAIT;
      end
      S_TX:     state_d = (cnt_q == TX_LAST) ? S_IDLE : S_TX;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    word_d   = word_q;
    tx_d     = tx_q;
    test_o_d = 1'b0;
    start_d  = 1'b0;
    busy_d   = (state_d != S_IDLE);
`ifdef EC_HARNESS_TIMEOUT_EN
    wd_d     = wd_q;
    clr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
      end
      S_RX: begin
        rx_d = {rx_q[IN_WIDTH-3:0], test_i};
        if (cnt_q == RX_LAST) begin
          word_d  = {rx_q, test_i};
          cnt_d   = CNT_ZERO;
          start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LAUNCH: begin
`ifdef EC_HARNESS_TIMEOUT_EN
        wd_d = WD_ZERO;
`endif
        cnt_d = CNT_ZERO;
      end
      S_WAIT: begin
        // Done has priority over an expiring watchdog in the same cycle.
        if (core_done) begin
          tx_d     = {1'b1, core_word_i};
          test_o_d = 1'b1;
          cnt_d    = CNT_ZERO;
        end else if (timeout_s) begin
          tx_d     = {(OUT_WIDTH+1){1'b0}};
          test_o_d = 1'b1;
          cnt_d    = CNT_ZERO;
`ifdef EC_HARNESS_TIMEOUT_EN
          clr_d    = 1'b1;
`endif
        end else begin
`ifdef EC_HARNESS_TIMEOUT_EN
          wd_d = wd_q + WD_ONE;
`endif
          cnt_d = CNT_ZERO;
        end
      end
      S_TX: begin
        tx_d = {tx_q[OUT_WIDTH-1:0], 1'b0};
        if (cnt_q == TX_LAST) begin
          test_o_d = 1'b0;
          cnt_d    = CNT_ZERO;
        end else begin
          test_o_d = tx_q[OUT_WIDTH];
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d = CNT_ZERO;
      end
    endcase
  end

  assign test_o      = test_o_q;
  assign core_word_o = word_q;
  assign core_start  = start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ec_serial_harness.sv
// Scoreboard bench for ec_serial_harness (IN=8, OUT=12, TIMEOUT=20); timeout cases need EC_HARNESS_TIMEOUT_EN.
module tb_ec_serial_harness;
  localparam int IW = 8;
  localparam int OW = 12;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          test_i = 1'b0;
  logic          core_done = 1'b0;
  logic [OW-1:0] core_word_i = '0;
  logic          test_o;
  logic [IW-1:0] core_word_o;
  logic          core_start;
  logic          core_clr;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int clr_exp = 0;
  int clr_seen = 0;
  logic [IW-1:0]   word_q[$];
  logic [OW+1:0]   frame_q[$];

  ec_serial_harness #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .test_i(test_i), .test_o(test_o),
    .core_word_o(core_word_o), .core_start(core_start), .core_clr(core_clr),
    .core_done(core_done), .core_word_i(core_word_i), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [IW-1:0] w);
    word_q.push_back(w);
    test_i = 1'b1;
    tick();
    for (int i = IW - 1; i >= 0; i--) begin
      test_i = w[i];
      tick();
    end
    test_i = 1'b0;
  endtask

  task automatic respond(input int d, input logic [OW-1:0] v);
    repeat (d) tick();
    core_done   = 1'b1;
    core_word_i = v;
    tick();
    core_done   = 1'b0;
    core_word_i = '0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("wait_idle_bound", 32'(busy), 32'd0);
  endtask

  // Launch monitor: operand and single-cycle start
  initial forever begin
    @(negedge clk);
    if (core_start === 1'b1) begin
      if (word_q.size() == 0) begin
        check("unexpected_core_start", 32'(core_start), 32'd0);
      end else begin
        check("core_word_o", 32'(core_word_o), 32'(word_q.pop_front()));
      end
      @(negedge clk);
      check("core_start_width", 32'(core_start), 32'd0);
    end
  end

  // Frame monitor: start, status, result and busy envelope
  initial forever begin
    @(negedge clk);
    if (test_o === 1'b1) begin
      logic [OW+1:0] got;
      int busy_bad;
      busy_bad = 0;
      got[OW+1] = 1'b1;
      if (busy !== 1'b1) busy_bad++;
      for (int i = OW; i >= 0; i--) begin
        @(negedge clk);
        got[i] = test_o;
        if (busy !== 1'b1) busy_bad++;
      end
      check("busy_in_frame", 32'(busy_bad), 32'd0);
      @(negedge clk);
      check("busy_after_frame", 32'(busy), 32'd0);
      check("test_o_after_frame", 32'(test_o), 32'd0);
      if (frame_q.size() == 0) check("unexpected_frame", 32'(got), 32'd0);
      else                     check("frame", 32'(got), 32'(frame_q.pop_front()));
    end
  end

  initial forever begin
    @(negedge clk);
    if (core_clr === 1'b1) clr_seen++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("rst_test_o", 32'(test_o), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_core_clr", 32'(core_clr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_word_o", 32'(core_word_o), 32'd0);
    rst = 1'b0;
    tick();

    // Basic transaction, done 5 cycles after start
    frame_q.push_back({1'b1, 1'b1, 12'h9C3});
    send_frame(8'hA5);
    respond(5, 12'h9C3);
    wait_idle();

    // Done in the LAUNCH cycle is ignored; tD sample is captured
    frame_q.push_back({1'b1, 1'b1, 12'h222});
    send_frame(8'h5A);
    core_done   = 1'b1;
    core_word_i = 12'h111;
    tick();
    core_word_i = 12'h222;
    tick();
    core_done   = 1'b0;
    core_word_i = '0;
    wait_idle();

    // Stray start bits during WAIT and TX are dropped
    frame_q.push_back({1'b1, 1'b1, 12'h3C3});
    send_frame(8'hC3);
    tick();
    test_i = 1'b1;
    tick();
    test_i = 1'b0;
    tick();
    core_done   = 1'b1;
    core_word_i = 12'h3C3;
    tick();
    core_done   = 1'b0;
    core_word_i = '0;
    repeat (3) tick();
    test_i = 1'b1;
    tick();
    test_i = 1'b0;
    wait_idle();
    frame_q.push_back({1'b1, 1'b1, 12'h5A7});
    send_frame(8'h3C);
    respond(3, 12'h5A7);
    wait_idle();

    // Reset in the middle of RX
    test_i = 1'b1;
    tick();
    test_i = 1'b1; tick();
    test_i = 1'b0; tick();
    test_i = 1'b1; tick();
    test_i = 1'b1; tick();
    rst    = 1'b1;
    test_i = 1'b0;
    tick();
    check("midrx_core_word_o", 32'(core_word_o), 32'd0);
    check("midrx_busy", 32'(busy), 32'd0);
    check("midrx_test_o", 32'(test_o), 32'd0);
    check("midrx_core_start", 32'(core_start), 32'd0);
    rst = 1'b0;
    repeat (6) tick();
    frame_q.push_back({1'b1, 1'b1, 12'h0F0});
    send_frame(8'h0F);
    respond(2, 12'h0F0);
    wait_idle();

    // Done on the 20th WAIT cycle: status 1 in either build
    frame_q.push_back({1'b1, 1'b1, 12'hABC});
    send_frame(8'h96);
    respond(TO, 12'hABC);
    wait_idle();

`ifdef EC_HARNESS_TIMEOUT_EN
    // Hung core: watchdog aborts with status 0 and zero result
    frame_q.push_back({1'b1, 1'b0, 12'h000});
    clr_exp++;
    send_frame(8'h77);
    wait_idle();
`else
    // No watchdog: WAIT persists well past TIMEOUT_CYCLES
    frame_q.push_back({1'b1, 1'b1, 12'h123});
    send_frame(8'h11);
    repeat (2 * TO) tick();
    check("wait_indefinite_busy", 32'(busy), 32'd1);
    respond(0, 12'h123);
    wait_idle();
`endif

    repeat (5) tick();
    check("word_queue_drained", 32'(word_q.size()), 32'd0);
    check("frame_queue_drained", 32'(frame_q.size()), 32'd0);
    check("core_clr_pulses", 32'(clr_seen), 32'(clr_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
